// File: rtl/urng_pair_packer.sv
// ============================================================================
// Module   : urng_pair_packer
// Purpose  : Packs pairs of 32-bit URNG words into Box-Muller operands
//            (u0 = 48 bits, u1 = 16 bits) and buffers them in a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module urng_pair_packer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [47:0] out_u0,
    output logic [15:0] out_u1,
    input  logic        out_ready,
    output logic [15:0] drop_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_FULL      = (c_PTR_W + 1)'(DEPTH);
    localparam logic [15:0]      c_DROP_MAX  = 16'hFFFF;

    typedef enum logic [0:0] {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    state_t               r_state;
    logic [31:0]          r_a;
    logic [47:0]          r_mem_u0 [DEPTH];
    logic [15:0]          r_mem_u1 [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W:0]     r_count;
    logic [47:0]          r_u0;
    logic [15:0]          r_u1;
    logic [15:0]          r_drop;

    logic                 w_in_xfer;
    logic                 w_pair;
    logic [47:0]          w_u0;
    logic [15:0]          w_u1;
    logic                 w_zero;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic [c_PTR_W-1:0]   w_rptr_n;
    logic [c_PTR_W:0]     w_count_n;
    logic                 w_head_new;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready   = (r_state == WAIT_A) || (r_count < c_FULL);
    assign out_valid  = (r_count != '0);
    assign out_u0     = r_u0;
    assign out_u1     = r_u1;
    assign drop_count = r_drop;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_pair     = w_in_xfer && (r_state == WAIT_B);
    assign w_u0       = {r_a, in_data[31:16]};
    assign w_u1       = in_data[15:0];
    assign w_zero     = (w_u0 == 48'd0);
    assign w_push     = w_pair && !w_zero;
    assign w_drop     = w_pair && w_zero;
    assign w_pop      = out_valid && out_ready;
    assign w_rptr_n   = r_rptr + c_PTR_W'(w_pop);
    // The slot being written this edge becomes the head when it is the next read slot.
    assign w_head_new = w_push && (r_wptr == w_rptr_n);

    always_comb begin
        w_count_n = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_n = r_count + 1'b1;
            2'b01:   w_count_n = r_count - 1'b1;
            default: w_count_n = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= WAIT_A;
            r_a     <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_u0    <= '0;
            r_u1    <= '0;
            r_drop  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_u0[i] <= '0;
                r_mem_u1[i] <= '0;
            end
        end else begin
            if (w_in_xfer) begin
                case (r_state)
                    WAIT_A: begin
                        r_a     <= in_data;
                        r_state <= WAIT_B;
                    end
                    default: r_state <= WAIT_A;
                endcase
            end

            if (w_push) begin
                r_mem_u0[r_wptr] <= w_u0;
                r_mem_u1[r_wptr] <= w_u1;
                r_wptr           <= r_wptr + 1'b1;
            end

            if (w_drop && (r_drop != c_DROP_MAX)) begin
                r_drop <= r_drop + 1'b1;
            end

            r_rptr  <= w_rptr_n;
            r_count <= w_count_n;

            // Output registers mirror the next head; they hold when the FIFO drains.
            if (w_count_n != '0) begin
                r_u0 <= w_head_new ? w_u0 : r_mem_u0[w_rptr_n];
                r_u1 <= w_head_new ? w_u1 : r_mem_u1[w_rptr_n];
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/urng_pair_packer.md
URNG_PAIR_PACKER -- requirements
Module: urng_pair_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output buffer depth in pairs (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream URNG word valid.
REQ-005 SHALL have port in_data  input  32  uniform random word from the Tausworthe stage.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port out_valid  output  1  a packed pair is presented.
REQ-008 SHALL have port out_u0  output  48  Box-Muller u0 operand.
REQ-009 SHALL have port out_u1  output  16  Box-Muller u1 operand.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the pair this cycle.
REQ-011 SHALL have port drop_count  output  16  saturating count of rejected pairs.

Function
REQ-012 SHALL treat an input transfer as in_valid=1 and in_ready=1 at a rising edge, and an output transfer as out_valid=1 and out_ready=1 at a rising edge.
REQ-013 SHALL implement an FSM with states WAIT_A and WAIT_B, and SHALL enter WAIT_A on reset.
REQ-014 In WAIT_A, an input transfer SHALL latch in_data into register A and move to WAIT_B. Without a transfer the FSM SHALL stay in WAIT_A.
REQ-015 In WAIT_B, an input transfer (word B) SHALL form u0={A, B[31:16]} and u1=B[15:0], then return to WAIT_A.
REQ-016 If the formed u0 equals 0 (log(0) guard), the pair SHALL be discarded rather than pushed, and drop_count SHALL increment by 1, saturating at 0xFFFF.
REQ-017 A nonzero pair SHALL be pushed into a DEPTH-entry FIFO in arrival order.
REQ-018 in_ready SHALL be 1 in WAIT_A, and SHALL be 1 in WAIT_B only when FIFO occupancy < DEPTH.
REQ-019 in_ready SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid SHALL equal (occupancy != 0).
REQ-021 out_u0 and out_u1 SHALL present the FIFO head.
REQ-022 out_u0 and out_u1 SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Latency SHALL be one cycle: with the FIFO empty, out_valid SHALL rise on the edge that accepts word B.
REQ-024 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-025 A push and a pop in the same cycle at occupancy DEPTH-1 SHALL be legal. (At occupancy DEPTH, push is blocked by REQ-018.)
REQ-026 FIFO read and write pointers SHALL wrap modulo DEPTH. Occupancy SHALL never exceed DEPTH or underflow below 0.
REQ-027 A dropped pair SHALL NOT change occupancy, and a pop SHALL still proceed in the same cycle.
REQ-028 When out_valid=0, out_u0 and out_u1 SHALL hold their last values, which are zero after reset.

Reset
REQ-029 While reset=0, the FSM SHALL be in WAIT_A, occupancy and pointers SHALL be 0, drop_count SHALL be 0, out_valid SHALL be 0, and out_u0/out_u1 SHALL be 0.
REQ-030 Reset assertion mid-pair SHALL discard the latched A word and all buffered pairs.
REQ-031 After reset release, the first accepted word SHALL be treated as word A.
REQ-032 No input or output transfer SHALL occur while reset=0.

Verification
REQ-033 Directed test 1: words 0x12345678 then 0x9ABCDEF0, out_ready=1 -> out_valid=1 on the edge accepting word 2, with out_u0=0x123456789ABC and out_u1=0xDEF0, for one cycle.
REQ-034 Directed test 2: words 0x00000000 then 0x0000FFFF -> no out_valid, and drop_count=1. Words 0x00000000 then 0x00010000 -> u0=0x000000000001 is emitted (not dropped).
REQ-035 Directed test 3: out_ready=0, stream 6 distinct words with DEPTH=2 -> occupancy reaches 2, the third pair's A word is latched, and in_ready=0 in WAIT_B. Then out_ready=1 -> three pairs emerge in order with no loss or duplication.
REQ-036 Directed test 4: FIFO at occupancy 1, then word B accepted in the same cycle as a pop -> occupancy stays 1 and the new pair becomes the head next cycle.
REQ-037 Directed test 5: reset pulsed low after word A, with one pair buffered -> out_valid=0 and drop_count=0 immediately. After release, words 0xAAAA0000 and 0x5555FFFF yield out_u0=0xAAAA00005555 and out_u1=0xFFFF.
REQ-038 Directed test 6: 65537 zero-u0 pairs -> drop_count reaches 0xFFFF and holds at 0xFFFF, and out_valid stays 0 throughout.
